// File: rtl/mem_port_arbiter.sv
// Two-port arbiter in front of the unified instruction/data memory.
// Port C is the multicycle CPU, port D the DMA/program loader. One
// fixed-latency memory transaction runs at a time; contention is
// resolved round-robin so continuous requesters strictly alternate.
module mem_port_arbiter #(
  parameter int AW  = 32,
  parameter int DW  = 32,
  parameter int LAT = 2   // read latency after the issue cycle, 1..15
) (
  input  logic          clk,
  input  logic          reset,
  // CPU port
  input  logic          c_req,
  input  logic          c_we,
  input  logic [AW-1:0] c_addr,
  input  logic [DW-1:0] c_wdata,
  output logic          c_ack,
  output logic [DW-1:0] c_rdata,
  // DMA port
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_ack,
  output logic [DW-1:0] d_rdata,
  // memory side
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  // status
  output logic          busy,
  output logic          gnt_d
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } state_t;

  // Counter is 4 bits wide, which caps LAT at 15.
  localparam logic [3:0] LAT_CNT = 4'(LAT);

  state_t          r_state;
  logic [3:0]      r_cnt;
  logic            r_last_d;     // 1 = DMA won the most recent grant
  logic            r_gnt_d;
  logic            r_busy;
  logic            r_mem_en;
  logic            r_mem_we;
  logic [AW-1:0]   r_mem_addr;
  logic [DW-1:0]   r_mem_wdata;
  logic            r_c_ack;
  logic            r_d_ack;
  logic [DW-1:0]   r_c_rdata;
  logic [DW-1:0]   r_d_rdata;

  logic            w_any_req;
  logic            w_pick_d;
  logic            w_sel_we;
  logic [AW-1:0]   w_sel_addr;
  logic [DW-1:0]   w_sel_wdata;

  // Arbitration: a lone requester wins; on contention the port that did
  // not win last time goes, which gives strict C/D alternation.
  assign w_any_req   = c_req | d_req;
  assign w_pick_d    = (c_req & d_req) ? ~r_last_d : d_req;
  assign w_sel_we    = w_pick_d ? d_we    : c_we;
  assign w_sel_addr  = w_pick_d ? d_addr  : c_addr;
  assign w_sel_wdata = w_pick_d ? d_wdata : c_wdata;

  // Transaction sequencer: IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
  // Requester inputs are captured only on the grant edge; everything the
  // memory and requesters see comes straight from registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_cnt       <= 4'd0;
      r_last_d    <= 1'b1;      // CPU wins the first tie
      r_gnt_d     <= 1'b0;
      r_busy      <= 1'b0;
      r_mem_en    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_c_ack     <= 1'b0;
      r_d_ack     <= 1'b0;
      r_c_rdata   <= '0;
      r_d_rdata   <= '0;
    end else begin
      // strobes are single-cycle unless re-armed below
      r_mem_en <= 1'b0;
      r_c_ack  <= 1'b0;
      r_d_ack  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_any_req) begin
            r_gnt_d     <= w_pick_d;
            r_last_d    <= w_pick_d;
            r_mem_we    <= w_sel_we;
            r_mem_addr  <= w_sel_addr;
            r_mem_wdata <= w_sel_wdata;
            r_mem_en    <= 1'b1;
            r_busy      <= 1'b1;
            r_state     <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          r_cnt   <= LAT_CNT;
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          r_cnt <= r_cnt - 4'd1;
          // cnt==1 is cycle issue+LAT, where the memory data is valid
          if (r_cnt == 4'd1) begin
            if (!r_mem_we) begin
              if (r_gnt_d) r_d_rdata <= mem_rdata;
              else         r_c_rdata <= mem_rdata;
            end
            if (r_gnt_d) r_d_ack <= 1'b1;
            else         r_c_ack <= 1'b1;
            r_state <= S_RESP;
          end
        end
        S_RESP: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign c_ack     = r_c_ack;
  assign d_ack     = r_d_ack;
  assign c_rdata   = r_c_rdata;
  assign d_rdata   = r_d_rdata;
  assign mem_en    = r_mem_en;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign busy      = r_busy;
  assign gnt_d     = r_gnt_d;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus a randomized run
// checked against a transaction-timeline model of the arbiter.
module tb_mem_port_arbiter;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int LAT = 2;

  logic clk = 1'b0;
  logic reset = 1'b1;

  // LAT=2 instance
  logic          c_req = 0, c_we = 0, d_req = 0, d_we = 0;
  logic [AW-1:0] c_addr = '0, d_addr = '0;
  logic [DW-1:0] c_wdata = '0, d_wdata = '0;
  logic          c_ack, d_ack, mem_en, mem_we, busy, gnt_d;
  logic [DW-1:0] c_rdata, d_rdata, mem_wdata, mem_rdata;
  logic [AW-1:0] mem_addr;

  // LAT=1 instance
  logic          c1_req = 0, c1_we = 0, d1_req = 0, d1_we = 0;
  logic [AW-1:0] c1_addr = '0, d1_addr = '0;
  logic [DW-1:0] c1_wdata = '0, d1_wdata = '0;
  logic          c1_ack, d1_ack, mem1_en, mem1_we, busy1, gnt1_d;
  logic [DW-1:0] c1_rdata, d1_rdata, mem1_wdata, mem1_rdata;
  logic [AW-1:0] mem1_addr;

  int n_pass = 0;
  int n_tot  = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.AW(AW), .DW(DW), .LAT(LAT)) dut (
    .clk(clk), .reset(reset),
    .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
    .c_ack(c_ack), .c_rdata(c_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .busy(busy), .gnt_d(gnt_d)
  );

  mem_port_arbiter #(.AW(AW), .DW(DW), .LAT(1)) dut1 (
    .clk(clk), .reset(reset),
    .c_req(c1_req), .c_we(c1_we), .c_addr(c1_addr), .c_wdata(c1_wdata),
    .c_ack(c1_ack), .c_rdata(c1_rdata),
    .d_req(d1_req), .d_we(d1_we), .d_addr(d1_addr), .d_wdata(d1_wdata),
    .d_ack(d1_ack), .d_rdata(d1_rdata),
    .mem_en(mem1_en), .mem_we(mem1_we), .mem_addr(mem1_addr),
    .mem_wdata(mem1_wdata), .mem_rdata(mem1_rdata),
    .busy(busy1), .gnt_d(gnt1_d)
  );

  // Initial memory image; word 16 (byte 0x40) holds the read test pattern.
  function automatic logic [31:0] init_word(int i);
    if (i == 16) return 32'hDEAD_BEEF;
    return 32'h1000_0000 + 32'(i) * 32'h0001_0101;
  endfunction

  // Memory for the LAT=2 instance: data is only valid exactly LAT cycles
  // after the issue cycle, garbage otherwise.
  logic [31:0] mem [0:255];
  logic [7:0]  rd_idx;
  logic [4:0]  rd_age;
  logic        rd_pend;
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 256; i++) mem[i] <= init_word(i);
      rd_idx  <= '0;
      rd_age  <= '0;
      rd_pend <= 1'b0;
    end else if (mem_en) begin
      if (mem_we) mem[mem_addr[9:2]] <= mem_wdata;
      rd_idx  <= mem_addr[9:2];
      rd_pend <= !mem_we;
      rd_age  <= 5'd1;
    end else if (rd_age != 5'd0 && rd_age != 5'd31) begin
      rd_age <= rd_age + 5'd1;
    end
  end
  always_comb mem_rdata = (rd_pend && rd_age == 5'(LAT)) ? mem[rd_idx]
                                                         : (32'hBAD0_0000 | 32'(rd_age));

  // Memory for the LAT=1 instance: valid only in the cycle after issue.
  logic        m1_hit;
  logic [31:0] m1_addr;
  always @(posedge clk) begin
    m1_hit  <= reset ? 1'b0 : mem1_en;
    m1_addr <= mem1_addr;
  end
  always_comb mem1_rdata = m1_hit ? (32'h5A00_0000 | m1_addr) : 32'hFFFF_FFFF;

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    c_req = 0; d_req = 0; c1_req = 0; d1_req = 0;
    c_we = 0; d_we = 0; c1_we = 0; d1_we = 0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    n_tot++;
    if ({c_ack, d_ack, mem_en, mem_we, busy, gnt_d} !== 6'b0) begin
      $display("FAIL reset_ctl: got %b want 000000", {c_ack, d_ack, mem_en, mem_we, busy, gnt_d});
    end else n_pass++;
    n_tot++;
    if ({mem_addr, mem_wdata, c_rdata, d_rdata} !== 128'h0) begin
      $display("FAIL reset_data: got %h want 0", {mem_addr, mem_wdata, c_rdata, d_rdata});
    end else n_pass++;
    n_tot++;
    if ({c1_ack, d1_ack, mem1_en, mem1_we, busy1, gnt1_d, mem1_addr, mem1_wdata, c1_rdata, d1_rdata} !== 134'h0) begin
      $display("FAIL reset_lat1: got %h want 0",
               {c1_ack, d1_ack, mem1_en, mem1_we, busy1, gnt1_d, mem1_addr, mem1_wdata, c1_rdata, d1_rdata});
    end else n_pass++;
    reset = 1'b0;
  endtask

  task automatic test_cpu_read();
    @(negedge clk);
    c_req = 1; c_we = 0; c_addr = 32'h40; c_wdata = 32'h0;
    for (int i = 1; i <= LAT + 2; i++) begin
      @(negedge clk);
      n_tot++;
      if (mem_en !== 1'(i == 1)) $display("FAIL cpu_rd_mem_en cyc %0d: got %b want %b", i, mem_en, i == 1);
      else n_pass++;
      n_tot++;
      if ({c_ack, d_ack} !== {1'(i == LAT + 2), 1'b0})
        $display("FAIL cpu_rd_ack cyc %0d: got %b want %b", i, {c_ack, d_ack}, {1'(i == LAT + 2), 1'b0});
      else n_pass++;
      if (i == 1) begin
        n_tot++;
        if ({mem_we, gnt_d, mem_addr} !== {2'b00, 32'h40})
          $display("FAIL cpu_rd_issue: got %h want %h", {mem_we, gnt_d, mem_addr}, {2'b00, 32'h40});
        else n_pass++;
      end
      if (i == LAT + 2) begin
        n_tot++;
        if (c_rdata !== 32'hDEAD_BEEF) $display("FAIL cpu_rd_data: got %h want deadbeef", c_rdata);
        else n_pass++;
        c_req = 0;
      end
    end
  endtask

  task automatic test_dma_write();
    @(negedge clk);
    d_req = 1; d_we = 1; d_addr = 32'h100; d_wdata = 32'h1234_5678;
    for (int i = 1; i <= LAT + 2; i++) begin
      @(negedge clk);
      n_tot++;
      if (mem_en !== 1'(i == 1)) $display("FAIL dma_wr_mem_en cyc %0d: got %b want %b", i, mem_en, i == 1);
      else n_pass++;
      n_tot++;
      if ({c_ack, d_ack} !== {1'b0, 1'(i == LAT + 2)})
        $display("FAIL dma_wr_ack cyc %0d: got %b want %b", i, {c_ack, d_ack}, {1'b0, 1'(i == LAT + 2)});
      else n_pass++;
      if (i == 1) begin
        n_tot++;
        if ({mem_we, gnt_d, mem_addr, mem_wdata} !== {2'b11, 32'h100, 32'h1234_5678})
          $display("FAIL dma_wr_issue: got %h want %h", {mem_we, gnt_d, mem_addr, mem_wdata},
                   {2'b11, 32'h100, 32'h1234_5678});
        else n_pass++;
      end
      if (i == LAT + 2) begin
        n_tot++;
        if (d_rdata !== 32'h0) $display("FAIL dma_wr_rdata_kept: got %h want 0", d_rdata);
        else n_pass++;
        d_req = 0; d_we = 0;
      end
    end
  endtask

  task automatic test_simultaneous();
    do_reset();
    c_req = 1; d_req = 1; c_we = 0; d_we = 0; c_addr = 32'h10; d_addr = 32'h20;
    for (int n = 0; n < 4; n++) begin
      for (int i = 1; i <= LAT + 3; i++) begin
        @(negedge clk);
        n_tot++;
        if (c_ack && d_ack) $display("FAIL both_acks txn %0d cyc %0d: got 11 want not 11", n, i);
        else n_pass++;
        if (i == 1) begin
          n_tot++;
          if ({mem_en, gnt_d} !== {1'b1, 1'(n % 2)})
            $display("FAIL rr_grant txn %0d: got %b want %b", n, {mem_en, gnt_d}, {1'b1, 1'(n % 2)});
          else n_pass++;
        end
        if (i == LAT + 2) begin
          n_tot++;
          if ({c_ack, d_ack} !== {1'(n % 2 == 0), 1'(n % 2 == 1)})
            $display("FAIL rr_ack txn %0d: got %b want %b", n, {c_ack, d_ack}, {1'(n % 2 == 0), 1'(n % 2 == 1)});
          else n_pass++;
          if (n == 3) begin c_req = 0; d_req = 0; end
        end
      end
    end
  endtask

  task automatic test_req_change();
    do_reset();
    c_req = 1; c_we = 0; c_addr = 32'h80;
    for (int i = 1; i <= 2 * LAT + 5; i++) begin
      @(negedge clk);
      if (i >= 1 && i <= LAT + 2) begin
        n_tot++;
        if ({mem_we, gnt_d, mem_addr} !== {2'b00, 32'h80})
          $display("FAIL chg_cpu_addr cyc %0d: got %h want %h", i, {mem_we, gnt_d, mem_addr}, {2'b00, 32'h80});
        else n_pass++;
      end
      if (i == 2) begin
        d_req = 1; d_we = 0; d_addr = 32'hC0;
        c_addr = 32'h44; c_we = 1; c_wdata = 32'hFFFF_0000;
      end
      if (i == LAT + 2) begin
        n_tot++;
        if ({c_ack, d_ack, c_rdata} !== {2'b10, init_word(32)})
          $display("FAIL chg_cpu_resp: got %h want %h", {c_ack, d_ack, c_rdata}, {2'b10, init_word(32)});
        else n_pass++;
        c_req = 0;
      end
      if (i == LAT + 3) begin
        n_tot++;
        if ({mem_en, busy} !== 2'b00) $display("FAIL chg_idle: got %b want 00", {mem_en, busy});
        else n_pass++;
      end
      if (i == LAT + 4) begin
        n_tot++;
        if ({mem_en, gnt_d, mem_we, mem_addr} !== {3'b110, 32'hC0})
          $display("FAIL chg_dma_issue: got %h want %h", {mem_en, gnt_d, mem_we, mem_addr}, {3'b110, 32'hC0});
        else n_pass++;
      end
      if (i == 2 * LAT + 5) begin
        n_tot++;
        if ({c_ack, d_ack, d_rdata} !== {2'b01, init_word(48)})
          $display("FAIL chg_dma_resp: got %h want %h", {c_ack, d_ack, d_rdata}, {2'b01, init_word(48)});
        else n_pass++;
        d_req = 0;
      end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    c_req = 1; c_we = 0; c_addr = 32'h40;
    repeat (2) @(negedge clk);
    n_tot++;
    if (busy !== 1'b1) $display("FAIL mid_busy_before: got %b want 1", busy);
    else n_pass++;
    reset = 1'b1;
    @(negedge clk);
    n_tot++;
    if ({c_ack, d_ack, mem_en, mem_we, busy, gnt_d, mem_addr, c_rdata} !== 70'h0)
      $display("FAIL mid_reset_state: got %h want 0", {c_ack, d_ack, mem_en, mem_we, busy, gnt_d, mem_addr, c_rdata});
    else n_pass++;
    reset = 1'b0; c_req = 0;
    for (int i = 0; i < LAT + 3; i++) begin
      @(negedge clk);
      n_tot++;
      if ({c_ack, d_ack, busy} !== 3'b000) $display("FAIL mid_no_ack cyc %0d: got %b want 000", i, {c_ack, d_ack, busy});
      else n_pass++;
    end
  endtask

  task automatic test_lat1();
    do_reset();
    c1_req = 1; c1_we = 0; c1_addr = 32'h24;
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      n_tot++;
      if ({mem1_en, c1_ack, d1_ack} !== {1'(i == 1), 1'(i == 3), 1'b0})
        $display("FAIL lat1_timing cyc %0d: got %b want %b", i, {mem1_en, c1_ack, d1_ack}, {1'(i == 1), 1'(i == 3), 1'b0});
      else n_pass++;
      if (i == 3) begin
        n_tot++;
        if (c1_rdata !== 32'h5A00_0024) $display("FAIL lat1_data: got %h want 5a000024", c1_rdata);
        else n_pass++;
        c1_req = 0;
      end
    end
  endtask

  task automatic rnd_c();
    c_we = 1'($urandom_range(0, 1));
    c_addr = {22'd0, 8'($urandom_range(0, 255)), 2'b00};
    c_wdata = $urandom;
  endtask

  task automatic rnd_d();
    d_we = 1'($urandom_range(0, 1));
    d_addr = {22'd0, 8'($urandom_range(0, 255)), 2'b00};
    d_wdata = $urandom;
  endtask

  // Model: the arbiter is a timeline of transactions. An arbitration
  // point at cycle k with a winner gives issue k+1, ack k+LAT+2 and the
  // next arbitration point k+LAT+3; with no requester, the next is k+1.
  task automatic test_random();
    logic [31:0] em [0:255];
    int   next_arb = 0, t_issue = -1, t_ack = -1, nfail = 0;
    bit   act = 0, last_d = 1, t_d = 0, t_we = 0, ack_c, ack_d;
    logic [31:0] t_addr = 0, t_wd = 0, t_rd = 0;
    logic [31:0] e_crd = 0, e_drd = 0, e_ma = 0, e_mwd = 0;
    logic e_mwe = 0, e_gnt = 0;
    logic [5:0]   e_ctl, o_ctl;
    logic [127:0] e_dat, o_dat;
    for (int i = 0; i < 256; i++) em[i] = init_word(i);
    do_reset();
    for (int k = 0; k < 2000; k++) begin
      if (k > 0) @(negedge clk);
      if (act && k == t_issue) begin e_gnt = t_d; e_mwe = t_we; e_ma = t_addr; e_mwd = t_wd; end
      if (act && k == t_ack && !t_we) begin
        if (t_d) e_drd = t_rd; else e_crd = t_rd;
      end
      ack_c = act && k == t_ack && !t_d;
      ack_d = act && k == t_ack && t_d;
      e_ctl = {act && k == t_issue, ack_c, ack_d, act && k >= t_issue && k <= t_ack, e_gnt, e_mwe};
      o_ctl = {mem_en, c_ack, d_ack, busy, gnt_d, mem_we};
      e_dat = {e_ma, e_mwd, e_crd, e_drd};
      o_dat = {mem_addr, mem_wdata, c_rdata, d_rdata};
      n_tot++;
      if (o_ctl !== e_ctl) begin
        nfail++;
        $display("FAIL rand_ctl cyc %0d: got %b want %b", k, o_ctl, e_ctl);
      end else n_pass++;
      n_tot++;
      if (o_dat !== e_dat) begin
        nfail++;
        $display("FAIL rand_data cyc %0d: got %h want %h", k, o_dat, e_dat);
      end else n_pass++;
      if (act && k == t_ack) act = 0;
      // stimulus: hold req until ack, then maybe re-request at once
      if (ack_c) begin c_req = 1'($urandom_range(0, 1)); rnd_c(); end
      else if (!c_req) begin if ($urandom_range(0, 3) == 0) begin c_req = 1; rnd_c(); end end
      else if ($urandom_range(0, 3) == 0) rnd_c();
      if (ack_d) begin d_req = 1'($urandom_range(0, 1)); rnd_d(); end
      else if (!d_req) begin if ($urandom_range(0, 3) == 0) begin d_req = 1; rnd_d(); end end
      else if ($urandom_range(0, 3) == 0) rnd_d();
      if (k == next_arb) begin
        if (c_req || d_req) begin
          if (c_req && d_req) t_d = !last_d;
          else t_d = d_req;
          last_d = t_d;
          act = 1;
          t_we = t_d ? d_we : c_we;
          t_addr = t_d ? d_addr : c_addr;
          t_wd = t_d ? d_wdata : c_wdata;
          if (t_we) em[t_addr[9:2]] = t_wd;
          else t_rd = em[t_addr[9:2]];
          t_issue = k + 1;
          t_ack = k + LAT + 2;
          next_arb = k + LAT + 3;
        end else begin
          next_arb = k + 1;
        end
      end
      if (nfail >= 20) break;
    end
    c_req = 0; d_req = 0;
    repeat (LAT + 4) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_cpu_read();
    test_dma_write();
    test_simultaneous();
    test_req_change();
    test_reset_mid();
    test_lat1();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
